// File: rtl/prefix_scan_pkg.sv
// Shared types for the streaming prefix-scan engine.
package prefix_scan_pkg;

  typedef enum logic {
    SCAN_INCL = 1'b0,
    SCAN_EXCL = 1'b1
  } scan_mode_e;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } fsm_state_e;

endpackage

// File: rtl/prefix_scan_lanes.sv
// Combinational LANES-wide prefix scan with carry-in; linear ripple chain.
module prefix_scan_lanes
  import prefix_scan_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]       carry_in,
  input  scan_mode_e             mode,
  input  logic [LANES*WIDTH-1:0] in_data,
  output logic [LANES*WIDTH-1:0] lane_out,
  output logic [WIDTH-1:0]       beat_sum
);

  logic [WIDTH-1:0] run;
  logic [WIDTH-1:0] word;

  // Exclusive lanes see the running value before adding their own word.
  always_comb begin
    run      = carry_in;
    word     = '0;
    lane_out = '0;
    beat_sum = '0;
    for (int k = 0; k < LANES; k++) begin
      word     = in_data[k*WIDTH +: WIDTH];
      beat_sum = beat_sum + word;
      if (mode == SCAN_EXCL) begin
        lane_out[k*WIDTH +: WIDTH] = run;
        run = run + word;
      end else begin
        run = run + word;
        lane_out[k*WIDTH +: WIDTH] = run;
      end
    end
  end

endmodule

// File: rtl/prefix_scan_stream.sv
// Streaming prefix-sum engine: scans LANES words per beat, carrying the
// running total across beats until the packet's last beat.
module prefix_scan_stream
  import prefix_scan_pkg::*;
#(
  parameter int LANES = 4,
  parameter int WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [LANES*WIDTH-1:0] in_data,
  input  logic                   in_last,
  input  logic                   in_mode,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [LANES*WIDTH-1:0] out_data,
  output logic                   out_last,
  output logic [WIDTH-1:0]       out_total
);

  fsm_state_e             state;
  fsm_state_e             next_state;
  scan_mode_e             mode_q;
  scan_mode_e             eff_mode;
  logic [WIDTH-1:0]       acc;
  logic [WIDTH-1:0]       beat_sum;
  logic [WIDTH-1:0]       packet_sum;
  logic [LANES*WIDTH-1:0] lane_out;
  logic                   accept;

  // Mode is latched only on a packet's first beat; later beats reuse it.
  assign eff_mode   = (state == IDLE) ? scan_mode_e'(in_mode) : mode_q;
  assign in_ready   = rst_n && !clear && (!out_valid || out_ready);
  assign accept     = in_valid && in_ready;
  assign packet_sum = acc + beat_sum;

  prefix_scan_lanes #(
    .LANES(LANES),
    .WIDTH(WIDTH)
  ) u_lanes (
    .carry_in(acc),
    .mode    (eff_mode),
    .in_data (in_data),
    .lane_out(lane_out),
    .beat_sum(beat_sum)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    if (clear) begin
      next_state = IDLE;
    end else if (accept) begin
      next_state = in_last ? IDLE : BUSY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= SCAN_INCL;
    end else if (accept && (state == IDLE) && !in_last) begin
      mode_q <= scan_mode_e'(in_mode);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clear) begin
      acc <= '0;
    end else if (accept) begin
      acc <= in_last ? '0 : packet_sum;
    end
  end

  // Single output stage: a new beat may load while the old one drains.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_total <= '0;
    end else if (clear) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
      out_total <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lane_out;
      out_last  <= in_last;
      out_total <= in_last ? packet_sum : '0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
